// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/MULTU/DIV/DIVU unit.
//   md_op_e    : operation encoding (low two bits of funct 0110xx)
//   md_state_e : control FSM state encoding
//   op_is_div / op_is_signed : operation class helpers
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIN  = 2'b10
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: one shift-add (multiply) or restoring (divide) step
// per cycle on unsigned magnitudes, plus the step counter.
// Ports:
//   CLK, RST           clock, asynchronous active-low reset
//   i_load             load operands, clear partial result and counter
//   i_is_div           operation class sampled on i_load
//   i_opa, i_opb       magnitudes: multiplicand/dividend, multiplier/divisor
//   i_step             perform one iteration this cycle
//   o_hi_nxt, o_lo_nxt partial result after the current step (combinational)
//                      mul: {hi,lo} = product; div: hi = remainder, lo = quotient
//   o_last             current step is the final one
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic [WIDTH-1:0] o_lo_nxt,
  output logic             o_last
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Multiply keeps the multiplier in r_lo and shifts product bits in from
  // the top; divide shifts dividend bits out of r_lo into the remainder.
  // The remainder is always below the divisor, so the trial difference fits
  // in WIDTH bits whenever it is kept.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_opb});
    w_diff  = w_shift[WIDTH-1:0] - r_opb;
    if (r_is_div) begin
      o_hi_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
      o_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi_nxt = w_sum[WIDTH:1];
      o_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_hi     <= '0;
      r_lo     <= i_opa;
      r_opb    <= i_opb;
      r_is_div <= i_is_div;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_hi     <= o_hi_nxt;
      r_lo     <= o_lo_nxt;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: control FSM, sign handling and the
// architectural HI/LO registers around the iterative datapath.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational
// MULT/MULTU (division stays iterative).
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   Start, Op       launch request and operation (MULT/MULTU/DIV/DIVU)
//   A, B            rs (multiplicand/dividend), rt (multiplier/divisor)
//   HiWe, LoWe,
//   Wdata           MTHI/MTLO write port, honoured only while not busy
//   Busy            operation in progress (CALC)
//   Done            one-cycle pulse after the result is committed
//   Hi, Lo          architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] Wdata,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  md_state_e r_state;
  md_state_e w_state_nxt;
  md_op_e    w_op_in;
  md_op_e    r_op;

  logic             w_accept;
  logic             w_step;
  logic             w_commit;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic             r_neg;
  logic             r_rneg;
  logic             r_divz;
  logic [WIDTH-1:0] r_a;

  logic [WIDTH-1:0]   w_it_hi;
  logic [WIDTH-1:0]   w_it_lo;
  logic               w_it_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  logic               w_fast;
  logic [2*WIDTH-1:0] w_fprod;

  assign w_op_in  = md_op_e'(Op);
  assign w_accept = Start && (r_state != ST_CALC);
  assign w_a_neg  = op_is_signed(w_op_in) && A[WIDTH-1];
  assign w_b_neg  = op_is_signed(w_op_in) && B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fa;
  logic [2*WIDTH-1:0] w_fb;
  assign w_fast  = !op_is_div(w_op_in);
  assign w_fa    = op_is_signed(w_op_in) ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
  assign w_fb    = op_is_signed(w_op_in) ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
  assign w_fprod = w_fa * w_fb;
`else
  assign w_fast  = 1'b0;
  assign w_fprod = '0;
`endif

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .CLK      (CLK),
    .RST      (RST),
    .i_load   (w_accept),
    .i_is_div (op_is_div(w_op_in)),
    .i_opa    (w_a_mag),
    .i_opb    (w_b_mag),
    .i_step   (w_step),
    .o_hi_nxt (w_it_hi),
    .o_lo_nxt (w_it_lo),
    .o_last   (w_it_last)
  );

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (Start) w_state_nxt = w_fast ? ST_FIN : ST_CALC;
        else       w_state_nxt = ST_IDLE;
      end
      ST_CALC: begin
        if (w_it_last) w_state_nxt = ST_FIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy     = 1'b0;
    Done     = 1'b0;
    w_step   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_CALC: begin
        Busy     = 1'b1;
        w_step   = 1'b1;
        w_commit = w_it_last;
      end
      ST_FIN:  Done = 1'b1;
      default: ;
    endcase
  end

  // Operation context captured at Start acceptance
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_op   <= MD_MULT;
      r_neg  <= 1'b0;
      r_rneg <= 1'b0;
      r_divz <= 1'b0;
      r_a    <= '0;
    end else if (w_accept) begin
      r_op   <= w_op_in;
      r_neg  <= w_a_neg ^ w_b_neg;
      r_rneg <= w_a_neg;
      r_divz <= (B == '0);
      r_a    <= A;
    end
  end

  // Sign fix-up on the final step's output so the commit lands on the last
  // CALC edge. Signed overflow (min / -1) needs no special case: magnitude
  // 2^(W-1) negated is the most-negative value again, remainder 0.
  always_comb begin
    w_prod = {w_it_hi, w_it_lo};
    if (r_neg) w_prod = -w_prod;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (op_is_div(r_op)) begin
      if (r_divz) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_lo = r_neg  ? -w_it_lo : w_it_lo;
        w_res_hi = r_rneg ? -w_it_hi : w_it_hi;
      end
    end
  end

  // HI/LO: a Start takes priority over same-cycle MTHI/MTLO writes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Hi <= '0;
      Lo <= '0;
    end else if (w_accept) begin
      if (w_fast) begin
        Hi <= w_fprod[2*WIDTH-1:WIDTH];
        Lo <= w_fprod[WIDTH-1:0];
      end
    end else if (w_commit) begin
      Hi <= w_res_hi;
      Lo <= w_res_lo;
    end else if (!Busy) begin
      if (HiWe) Hi <= Wdata;
      if (LoWe) Lo <= Wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         HiWe;
  logic         LoWe;
  logic [W-1:0] Wdata;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .HiWe  (HiWe),
    .LoWe  (LoWe),
    .Wdata (Wdata),
    .Busy  (Busy),
    .Done  (Done),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} straight from the operation's arithmetic meaning
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] up;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (op)
      OP_MULT: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Behavioural model: cycles of busy remaining, pending result, HI/LO, done pulse
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic [63:0]  m_r;
  int           m_calc = 0;
  bit           m_done = 1'b0;
  bit           m_fast;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_hi = '0; m_lo = '0; m_calc = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_calc > 0) begin
        m_calc--;
        if (m_calc == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (Start) begin
        m_r = ref_res(Op, A, B);
`ifdef MULDIV_FAST_MUL_EN
        m_fast = !Op[1];
`else
        m_fast = 1'b0;
`endif
        if (m_fast) begin
          m_hi = m_r[63:32]; m_lo = m_r[31:0]; m_done = 1'b1;
        end else begin
          p_hi = m_r[63:32]; p_lo = m_r[31:0]; m_calc = W;
        end
      end else begin
        if (HiWe) m_hi = Wdata;
        if (LoWe) m_lo = Wdata;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_busy", {63'd0, Busy}, {63'd0, (m_calc > 0)});
      check("cyc_done", {63'd0, Done}, {63'd0, m_done});
      check("cyc_hi", {32'd0, Hi}, {32'd0, m_hi});
      check("cyc_lo", {32'd0, Lo}, {32'd0, m_lo});
    end
  end

  task automatic wait_done(output int lat);
    bit got;
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (Done) begin got = 1'b1; break; end
      @(posedge CLK); #1;
      lat++;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no Done within 60 cycles, required Done");
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(lat);
  endtask

  task automatic write_reg(input bit hi, input logic [31:0] d);
    HiWe = hi; LoWe = !hi; Wdata = d;
    @(posedge CLK); #1;
    HiWe = 1'b0; LoWe = 1'b0;
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int lat;
  int done_seen;

  initial begin
    RST = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0;
    HiWe = 1'b0; LoWe = 1'b0; Wdata = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    check("rst_hi", {32'd0, Hi}, 64'd0);
    check("rst_lo", {32'd0, Lo}, 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    do_op(OP_MULT, 32'd5, 32'd3, lat);
    check("mult5x3_lat", 64'(lat), 64'(MUL_LAT));
    check("mult5x3_hi", {32'd0, Hi}, 64'h0);
    check("mult5x3_lo", {32'd0, Lo}, 64'hF);

    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat);
    check("mult_neg_hi", {32'd0, Hi}, 64'hFFFF_FFFF);
    check("mult_neg_lo", {32'd0, Lo}, 64'hFFFF_FFFA);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_max_hi", {32'd0, Hi}, 64'hFFFF_FFFE);
    check("multu_max_lo", {32'd0, Lo}, 64'h1);

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_lat", 64'(lat), 64'(DIV_LAT));
    check("div_neg_lo", {32'd0, Lo}, 64'hFFFF_FFFD);
    check("div_neg_hi", {32'd0, Hi}, 64'hFFFF_FFFF);

    do_op(OP_DIVU, 32'hF, 32'd0, lat);
    check("divz_lat", 64'(lat), 64'(DIV_LAT));
    check("divz_lo", {32'd0, Lo}, 64'hFFFF_FFFF);
    check("divz_hi", {32'd0, Hi}, 64'hF);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_lo", {32'd0, Lo}, 64'h8000_0000);
    check("div_ovf_hi", {32'd0, Hi}, 64'h0);

    // Second Start and MTHI while busy are both ignored
    Op = OP_DIVU; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    Op = OP_MULT; A = 32'd9; B = 32'd9; Start = 1'b1; HiWe = 1'b1; Wdata = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    Start = 1'b0; HiWe = 1'b0;
    wait_done(lat);
    check("busy_ign_lat", 64'(lat), 64'(DIV_LAT - 6));
    check("busy_ign_lo", {32'd0, Lo}, 64'd14);
    check("busy_ign_hi", {32'd0, Hi}, 64'd2);

    // MTHI/MTLO when idle; write dropped when paired with Start
    @(posedge CLK); #1;
    write_reg(1'b1, 32'h1234_5678);
    check("mthi", {32'd0, Hi}, 64'h1234_5678);
    write_reg(1'b0, 32'h0BAD_F00D);
    check("mtlo", {32'd0, Lo}, 64'h0BAD_F00D);
    Op = OP_DIVU; A = 32'd6; B = 32'd4; Start = 1'b1; HiWe = 1'b1; Wdata = 32'hCAFE_BABE;
    @(posedge CLK); #1;
    Start = 1'b0; HiWe = 1'b0;
    @(negedge CLK);
    check("wr_drop_hold", {32'd0, Hi}, 64'h1234_5678);
    wait_done(lat);
    check("wr_drop_hi", {32'd0, Hi}, 64'd2);
    check("wr_drop_lo", {32'd0, Lo}, 64'd1);

    // Reset in the middle of CALC
    @(posedge CLK); #1;
    write_reg(1'b1, 32'hA5A5_A5A5);
    Op = OP_DIVU; A = 32'd1000; B = 32'd3; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_done", {63'd0, Done}, 64'd0);
    check("abort_hi", {32'd0, Hi}, 64'd0);
    check("abort_lo", {32'd0, Lo}, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Randomised traffic; the per-cycle compare does the checking
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLK); #1;
      Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          Start = 1'b1; Op = 2'($urandom_range(0, 3));
          A = rnd_opnd(); B = rnd_opnd();
          HiWe = 1'($urandom_range(0, 1)); Wdata = $urandom;
        end
        3: begin HiWe = 1'b1; Wdata = $urandom; end
        4: begin LoWe = 1'b1; Wdata = $urandom; end
        5: begin HiWe = 1'b1; LoWe = 1'b1; Wdata = $urandom; end
        default: ;
      endcase
    end
    @(posedge CLK); #1;
    Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
